// File: rtl/imem_loader_if.sv
// Boot loader bus bundle: byte stream handshake in, IMEM write port and
// core control out. The loader uses the slave view; the byte source/host
// side uses the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 32
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  modport master (
    output in_data, in_valid, load_req,
    input  in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
  );

  modport slave (
    input  in_data, in_valid, load_req,
    output in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Parses a length-prefixed, checksummed byte
// frame, writes each assembled little-endian word into IMEM and keeps the
// core in reset until a complete image has been verified.
module imem_loader #(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wordIdx_q, wordIdx_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       wordBuf_q, wordBuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic [7:0]        sumNext;
  logic [15:0]       lenFull;

  assign bus.in_ready = (state_q != DONE) && (state_q != ERR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign sumNext      = sum_q + bus.in_data;
  assign lenFull      = {bus.in_data, len_q[7:0]};

  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ERR);

  // Frame parser: next state, running checksum, word assembly and write strobe.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    len_d     = len_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    wordBuf_d = wordBuf_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      LEN0: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          sum_d      = sumNext;
          state_d    = LEN1;
        end
      end

      LEN1: begin
        if (accept) begin
          len_d     = lenFull;
          sum_d     = sumNext;
          wordIdx_d = '0;
          byteIdx_d = '0;
          if ({1'b0, lenFull} > DEPTH_L) begin
            state_d = ERR;
          end else if (lenFull == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          sum_d = sumNext;
          if (byteIdx_q == 2'd3) begin
            we_d      = 1'b1;
            wdata_d   = {bus.in_data, wordBuf_q};
            waddr_d   = BASE + (ADDR_W'(wordIdx_q) << 2);
            wordIdx_d = wordIdx_q + 16'd1;
            byteIdx_d = '0;
            if (wordIdx_q == len_q - 16'd1) begin
              state_d = CSUM;
            end
          end else begin
            case (byteIdx_q)
              2'd0:    wordBuf_d[7:0]   = bus.in_data;
              2'd1:    wordBuf_d[15:8]  = bus.in_data;
              default: wordBuf_d[23:16] = bus.in_data;
            endcase
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end

      CSUM: begin
        if (accept) begin
          sum_d   = sumNext;
          state_d = (sumNext == 8'd0) ? DONE : ERR;
        end
      end

      DONE, ERR: begin
        if (bus.load_req) begin
          state_d   = LEN0;
          sum_d     = '0;
          wordIdx_d = '0;
          byteIdx_d = '0;
        end
      end

      default: state_d = LEN0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LEN0;
      sum_q     <= '0;
      len_q     <= '0;
      wordIdx_q <= '0;
      byteIdx_q <= '0;
      wordBuf_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= BASE;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      len_q     <= len_d;
      wordIdx_q <= wordIdx_d;
      byteIdx_q <= byteIdx_d;
      wordBuf_q <= wordBuf_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the RISC-V core's instruction memory from a byte stream and holds the core in reset until a complete, checksum-verified image is in place. It sits between a byte source (UART receiver, debug port) and the IMEM write port, alongside `RiscV`. Its `core_rst` output drives the core's `rst`. It replaces file-based IMEM preloading for hardware builds.

## Interface
Parameters:
- `ADDR_W`, 32: IMEM byte-address width.
- `DEPTH`, 256: IMEM capacity in 32-bit words; the largest accepted image.
- `BASE`, 0: byte address of the first loaded word; must be word-aligned.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `load_req` in 1: request a new load. Honoured only in DONE or ERR.
- `imem_we` out 1: IMEM write strobe, a one-cycle pulse.
- `imem_waddr` out ADDR_W: byte address of the write.
- `imem_wdata` out 32: write data.
- `core_rst` out 1: reset to the core. High whenever the loader is not in DONE.
- `done` out 1: the image was loaded and verified.
- `err` out 1: the load was rejected.

## Operation
Frame format, all bytes in transfer order:
- Two bytes of length N, in 32-bit words, little-endian.
- N words, each sent as 4 bytes, least significant byte first.
- One checksum byte C. The 8-bit sum of every frame byte (length, payload and C) must be 0x00 modulo 256.

FSM states: LEN0, LEN1, DATA, CSUM, DONE, ERR.
- LEN0: accept the low length byte, then go to LEN1.
- LEN1: accept the high length byte, then:
  - if N > DEPTH, go to ERR;
  - if N == 0, go to CSUM;
  - otherwise go to DATA with word index k = 0 and byte index b = 0.
- DATA: shift each accepted byte into the word register at byte lane b.
  - On the 4th byte (b = 3), issue the IMEM write of word k, then increment k.
  - Go to CSUM after word N−1.
- CSUM: accept C. If the running sum including C is 0x00, go to DONE; otherwise go to ERR.
- DONE and ERR: `in_ready` = 0. The state is held until `load_req` = 1, which moves to LEN0 and clears the running sum, k, b, `done` and `err`.
- Running sum: 8-bit, wraps modulo 256. It is updated on every accepted byte in LEN0, LEN1, DATA and CSUM.
- `in_ready` = 1 in LEN0, LEN1, DATA and CSUM. There is no other backpressure source.
- `imem_waddr` = BASE + 4·k, truncated to ADDR_W bits.
- `imem_wdata` = {byte3, byte2, byte1, byte0}.
- Words already written before an ERR or a reset are not erased. The core stays in reset, so they are never executed.

## Timing
Reset values (the cycle after `rst` is sampled high):
- state = LEN0, `in_ready` = 1, `core_rst` = 1
- `imem_we` = 0, `imem_waddr` = BASE, `imem_wdata` = 0
- `done` = 0, `err` = 0, running sum = 0, k = 0, b = 0

Cycle-level behaviour:
- `imem_we` is registered. It is high for exactly the one cycle following the edge that accepted the word's 4th byte. `imem_waddr` and `imem_wdata` are valid in that same cycle.
- Back-to-back bytes (one per cycle) are accepted with no stalls. The final word's write pulse may coincide with the cycle in which the checksum byte is accepted.
- `done` rises and `core_rst` falls in the cycle after the edge that accepted a correct C. The core therefore leaves reset one cycle after the last frame byte.
- `err` rises one cycle after the edge that accepted a bad C, or after the edge that accepted a LEN1 byte making N > DEPTH. `core_rst` stays 1.
- `load_req` in DONE: `core_rst` = 1 and `done` = 0 in the next cycle, so the core re-enters reset immediately.
- `load_req` in any state other than DONE or ERR is ignored.
- `in_valid` while `in_ready` = 0: the byte is not consumed and no state changes.
- `rst` mid-frame: the partial word is discarded and the loader returns to the reset values. `rst` takes precedence over `load_req` and over a byte transfer in the same cycle.

## Test plan
- Reset, then send N=1 as 01 00 13 82 A0 00 CA, one byte per cycle:
  - exactly one `imem_we` pulse, with `imem_waddr` = 0x0 and `imem_wdata` = 0x00A08213;
  - `done` = 1 and `core_rst` = 0 one cycle after CA.
- Send the 8-word program 0x00039037, 0x000030B7, 0x00015137, 0x000101B7, 0x00A08213, 0x000202B3, 0x00312123, 0x00212083 with a correct checksum and random `in_valid` gaps:
  - 8 writes at addresses 0x00, 0x04, …, 0x1C with matching data;
  - `done` = 1.
- Same single-word frame but with C = 0xCB: the write still occurs; `err` = 1, `core_rst` stays 1, `in_ready` = 0.
- Length edge cases:
  - N = DEPTH+1 (01 01 with DEPTH=256): `err` = 1 right after the second byte, with no writes.
  - N = 0 (00 00 00): `done` = 1 with no writes.
- Assert `rst` after 2 payload bytes, then send a full valid frame:
  - no write comes from the partial word;
  - the new frame loads starting at address BASE;
  - `core_rst` stays 1 until its `done`.
- From DONE, pulse `load_req`: `core_rst` = 1 and `done` = 0 the next cycle. Then reload a valid frame and check that it succeeds.
